// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register, optional two-entry skid buffer
// Define PIPE_STAGE_SKID_EN for the skid variant with registered in_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [15:0]       stall_cnt
);

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Saturating back-pressure counter; flush deliberately leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t            state;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_data  <= '0;
      out_ctrl  <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state    <= ONE;
            out_data <= in_data;
            out_ctrl <= in_ctrl;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            out_data <= in_data;
            out_ctrl <= in_ctrl;
          end else if (in_fire) begin
            // Downstream stalled: park the new beat behind the held one.
            state     <= TWO;
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state    <= ONE;
            out_data <= skid_data;
            out_ctrl <= skid_ctrl;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
`else
  typedef enum logic {EMPTY = 1'b0, ONE = 1'b1} state_t;

  state_t state;

  // Without a skid slot the stage can only refill in the cycle it drains.
  assign in_ready  = !out_valid | out_ready;
  assign out_valid = (state == ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_ctrl <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else if (in_fire) begin
      state    <= ONE;
      out_data <= in_data;
      out_ctrl <= in_ctrl;
    end else if (out_fire) begin
      state <= EMPTY;
    end
  end
`endif

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload data width (ALU result or memory read value).
REQ-002 SHALL have parameter CTRL_W, default 6, sideband width (write-back enable, memory-read enable, destination register).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  synchronous discard of all held beats.
REQ-006 SHALL have port in_valid  input  1  upstream beat present.
REQ-007 SHALL have port in_ready  output  1  stage accepts a beat this cycle.
REQ-008 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-009 SHALL have port in_ctrl  input  CTRL_W  upstream sideband.
REQ-010 SHALL have port out_valid  output  1  downstream beat present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts.
REQ-012 SHALL have port out_data  output  DATA_W  held payload.
REQ-013 SHALL have port out_ctrl  output  CTRL_W  held sideband.
REQ-014 SHALL have port stall_cnt  output  16  count of back-pressured cycles.

Function
REQ-015 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-016 SHALL forward a beat accepted at edge N on out_data/out_ctrl with out_valid=1 from edge N onward (1-cycle latency).
REQ-017 SHALL preserve beat order; no beat dropped or duplicated, except by flush.
REQ-018 SHALL hold out_data, out_ctrl and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 With skid enabled, SHALL use states EMPTY, ONE (main register full) and TWO (main and skid registers full).
REQ-020 EMPTY: in_fire -> ONE; otherwise stay in EMPTY.
REQ-021 ONE: in_fire only -> TWO (new beat to skid); out_fire only -> EMPTY; both -> ONE (new beat to main); neither -> ONE.
REQ-022 TWO: out_fire -> ONE (skid beat moves to main); otherwise stay in TWO.
REQ-023 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO, decoded from registered state only, with no path from out_ready.
REQ-024 out_valid SHALL be 1 in ONE and TWO.
REQ-025 flush=1 SHALL force EMPTY at the next edge, overriding any simultaneous in_fire/out_fire; a beat accepted in that cycle is discarded.
REQ-026 stall_cnt SHALL increment each cycle out_valid=1 and out_ready=0, saturate at 0xFFFF and not wrap, and be unaffected by flush.
REQ-027 In EMPTY, out_data/out_ctrl SHALL retain their last values.

Reset
REQ-028 rst=1 SHALL immediately set state EMPTY, out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0, with the skid register cleared to 0.
REQ-029 While rst=1, in_ready SHALL read 1 (EMPTY) and all inputs SHALL be ignored; reset mid-transfer SHALL discard held beats.

Configuration
REQ-030 Macro PIPE_STAGE_SKID_EN defined: the two-entry skid behaviour of REQ-019..REQ-023 SHALL apply, giving full throughput with registered in_ready.
REQ-031 Macro PIPE_STAGE_SKID_EN undefined: no skid register and states EMPTY/ONE only; in_ready SHALL equal !out_valid | out_ready (combinational), with all other requirements unchanged.

Verification
REQ-032 Reset, then in_data=0x0000_00A5 and in_ctrl=0x2B valid for 1 cycle, out_ready=1 -> out_valid=1 with 0xA5/0x2B one cycle later, then EMPTY.
REQ-033 Stream 0x1..0x8 with out_ready=1 -> outputs 0x1..0x8 in order, one per cycle, and in_ready stays 1.
REQ-034 Skid enabled: out_ready=0, push 0x11 then 0x22 -> in_ready=0 after the second push and out_data=0x11; release out_ready -> 0x11 then 0x22, and in_ready returns to 1.
REQ-035 State TWO with flush=1 and in_valid=1 (0x33) in the same cycle -> next cycle out_valid=0, and 0x33 never appears.
REQ-036 Hold out_valid=1 with out_ready=0 for 70000 cycles -> stall_cnt=0xFFFF, no wrap; assert rst mid-run -> stall_cnt=0 and out_valid=0 immediately.
REQ-037 Macro undefined: out_ready=0 with one beat held -> in_ready=0; out_ready=1 in the same cycle -> in_ready=1 combinationally, and the new beat is accepted.
